trap_peak_detect: RTL

//  Pulse-height analyser on the trapezoid output of the shaper: consumes signed trapezoid samples,

---
 rtl/trap_pha_pkg.sv | 27 ++
 rtl/pha_event_reg.sv | 53 +++++
 rtl/trap_peak_detect.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/trap_pha_pkg.sv
// Shared types and defaults for the trapezoid pulse-height analyser: FSM states, event layout, default shaper geometry.
package trap_pha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_TOP,
        ST_HOLD
    } pha_state_t;

    localparam int K_DEF     = 100;
    localparam int L_DEF     = 200;
    localparam int DW_DEF    = 16;
    localparam int TSW_DEF   = 32;
    localparam int GUARD_DEF = 8;

    // Baseline is averaged over fixed blocks so the divide is a plain arithmetic shift.
    localparam int BL_LEN    = 16;
    localparam int BL_SHIFT  = 4;

    typedef struct packed {
        logic                      pileup;
        logic [TSW_DEF-1:0]        ts;
        logic signed [DW_DEF-1:0]  height;
    } pha_event_t;

endpackage

// File: rtl/pha_event_reg.sv
// One-entry event holding register with saturating drop counter; load visible one clk later.
// Holds its word until out_vld_o & out_rdy_i; a new event arriving while full and not drained is dropped.
module pha_event_reg #(
    parameter int W = 49
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         evt_vld_i,
    input  logic [W-1:0] evt_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o,
    output logic [15:0]  drop_cnt_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;
    logic [15:0]  drop_q, drop_d;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        drop_d = drop_q;
        if (evt_vld_i) begin
            // Same-clk accept frees the slot, so the new event replaces the outgoing one.
            if (!vld_q || out_rdy_i) begin
                vld_d = 1'b1;
                dat_d = evt_dat_i;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (vld_q && out_rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            drop_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            drop_q <= drop_d;
        end
    end

    assign out_vld_o  = vld_q;
    assign out_dat_o  = dat_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: rtl/trap_peak_detect.sv
// Pulse-height analyser: threshold trigger, mid flat-top capture, one event per pulse; event valid one clk after the
// terminating sample, held until ev_ready (overflow counted in drop_cnt). Optional BASELINE_RESTORE_EN subtracts a block-averaged baseline.
module trap_peak_detect
    import trap_pha_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int L     = L_DEF,
    parameter int DW    = DW_DEF,
    parameter int TSW   = TSW_DEF,
    parameter int GUARD = GUARD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] trap_in,
    input  logic                 blank,
    input  logic signed [DW-1:0] thresh,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic signed [DW-1:0] ev_height,
    output logic [TSW-1:0]       ev_time,
    output logic                 ev_pileup,
    output logic [15:0]          drop_cnt
);

    localparam int CAP_N  = K + L / 2;
    localparam int PILE_N = 2 * K + L + GUARD;
    localparam int NW     = $clog2(PILE_N + 1);
    localparam int HW     = $clog2(K + 1);
    localparam int EVW    = DW + TSW + 1;

    pha_state_t           state_q;
    logic [NW-1:0]        n_q;
    logic [HW-1:0]        hold_q;
    logic [TSW-1:0]       ts_q;
    logic [TSW-1:0]       ts_lat_q;
    logic signed [DW-1:0] cap_q;
    logic                 pile_q;

    logic                 above;
    logic                 emit;
    logic signed [DW-1:0] cap_val;
    logic [EVW-1:0]       ev_dat;

    assign above = trap_in > thresh;
    assign emit  = (state_q == ST_TOP) && !above && !blank;

`ifdef BASELINE_RESTORE_EN
    logic signed [DW+3:0]  acc_q;
    logic signed [DW+3:0]  acc_sum;
    logic [BL_SHIFT-1:0]   bcnt_q;
    logic signed [DW-1:0]  base_q;
    logic signed [DW:0]    diff;

    assign acc_sum = acc_q + (DW+4)'(trap_in);
    assign diff    = (DW+1)'(trap_in) - (DW+1)'(base_q);

    always_comb begin
        cap_val = diff[DW-1:0];
        if (diff[DW] != diff[DW-1]) begin
            cap_val = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    // Baseline only tracks while idle so it stays frozen across the pulse being measured.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            bcnt_q <= '0;
            base_q <= '0;
        end else if (state_q == ST_IDLE && !blank) begin
            if (bcnt_q == BL_SHIFT'(BL_LEN - 1)) begin
                base_q <= acc_sum[DW+3:BL_SHIFT];
                acc_q  <= '0;
                bcnt_q <= '0;
            end else begin
                acc_q  <= acc_sum;
                bcnt_q <= bcnt_q + BL_SHIFT'(1);
            end
        end
    end
`else
    assign cap_val = trap_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            hold_q   <= '0;
            ts_q     <= '0;
            ts_lat_q <= '0;
            cap_q    <= '0;
            pile_q   <= 1'b0;
        end else begin
            ts_q <= ts_q + TSW'(1);
            if (blank) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (above) begin
                            state_q  <= ST_ARM;
                            n_q      <= NW'(1);
                            ts_lat_q <= ts_q;
                            pile_q   <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (!above) begin
                            state_q <= ST_IDLE;
                        end else begin
                            if (n_q == NW'(CAP_N)) begin
                                cap_q   <= cap_val;
                                state_q <= ST_TOP;
                            end
                            n_q <= n_q + NW'(1);
                        end
                    end
                    ST_TOP: begin
                        if (!above) begin
                            state_q <= ST_HOLD;
                            hold_q  <= '0;
                        end else if (n_q == NW'(PILE_N)) begin
                            pile_q <= 1'b1;
                        end else begin
                            n_q <= n_q + NW'(1);
                        end
                    end
                    ST_HOLD: begin
                        // Sit out the undershoot tail; re-triggers here are ignored.
                        if (hold_q == HW'(K - 1)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    pha_event_reg #(
        .W (EVW)
    ) u_event_reg (
        .clk        (clk),
        .rst        (rst),
        .evt_vld_i  (emit),
        .evt_dat_i  ({pile_q, ts_lat_q, cap_q}),
        .out_vld_o  (ev_valid),
        .out_rdy_i  (ev_ready),
        .out_dat_o  (ev_dat),
        .drop_cnt_o (drop_cnt)
    );

    assign {ev_pileup, ev_time, ev_height} = ev_dat;

endmodule
